// File: rtl/dfr_output_fifo_if.sv
// Producer/consumer bus of the DFR output FIFO: write strobe, FWFT read
// handshake, occupancy status and the flush/overflow-clear controls.
interface dfr_output_fifo_if #(
  parameter int AW = 4
);
  logic          clear;
  logic          wr_en;
  logic [25:0]   wr_data;
  logic          rd_ready;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          overflow_clr;

  modport master (
    output clear, wr_en, wr_data, rd_ready, overflow_clr,
    input  rd_valid, rd_data, count, full, empty, overflow
  );

  modport slave (
    input  clear, wr_en, wr_data, rd_ready, overflow_clr,
    output rd_valid, rd_data, count, full, empty, overflow
  );
endinterface

// File: rtl/dfr_output_fifo.sv
// First-word-fall-through FIFO buffering 26-bit DFR results for a 32-bit
// consumer; writes into a full FIFO are dropped and latched in a sticky flag.
module dfr_output_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  dfr_output_fifo_if.slave   bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [25:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          ovf;

  logic is_full;
  logic is_empty;
  logic rd_fire;
  logic wr_acc;
  logic wr_drop;

  always_comb begin
    is_full  = (cnt == FULL_CNT);
    is_empty = (cnt == '0);
    rd_fire  = !is_empty && bus.rd_ready;
    // a read in the same cycle frees the slot, so a full FIFO still accepts
    wr_acc   = bus.wr_en && (!is_full || rd_fire);
    wr_drop  = bus.wr_en && !wr_acc;
  end

  // Storage has no reset; flush/reset cycles must not disturb it.
  always_ff @(posedge clk) begin
    if (!reset && !bus.clear && wr_acc)
      mem[wp] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (wr_acc)
        wp <= wp + 1'b1;
      if (rd_fire)
        rp <= rp + 1'b1;
      if (wr_acc && !rd_fire)
        cnt <= cnt + 1'b1;
      else if (rd_fire && !wr_acc)
        cnt <= cnt - 1'b1;
      if (wr_drop)
        ovf <= 1'b1;
      else if (bus.overflow_clr)
        ovf <= 1'b0;
    end
  end

  assign bus.rd_valid = !is_empty;
  assign bus.rd_data  = {6'b000000, mem[rp]};
  assign bus.count    = cnt;
  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_dfr_output_fifo.sv
// Bench for dfr_output_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dfr_output_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dfr_output_fifo_if #(.AW(AW)) bus ();

  dfr_output_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queue of stored samples plus the sticky flag.
  logic [25:0] q [$];
  logic        m_ovf  = 1'b0;
  logic        m_ok   = 1'b0;

  always @(posedge clk) begin
    if (reset || bus.clear) begin
      q.delete();
      m_ovf = 1'b0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      bit fire, acc;
      fire = (q.size() > 0) && bus.rd_ready;
      acc  = bus.wr_en && ((q.size() < DEPTH) || fire);
      if (fire) void'(q.pop_front());
      if (acc) q.push_back(bus.wr_data);
      if (bus.wr_en && !acc) m_ovf = 1'b1;
      else if (bus.overflow_clr) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_count",    32'(bus.count),    32'(q.size()));
      chk("m_rd_valid", 32'(bus.rd_valid), 32'(q.size() != 0));
      chk("m_full",     32'(bus.full),     32'(q.size() == DEPTH));
      chk("m_empty",    32'(bus.empty),    32'(q.size() == 0));
      chk("m_overflow", 32'(bus.overflow), 32'(m_ovf));
      if (q.size() != 0)
        chk("m_rd_data", bus.rd_data, {6'b000000, q[0]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clear        = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_data      = '0;
    bus.rd_ready     = 1'b0;
    bus.overflow_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 26'(i);
      cyc();
    end
    idle();
  endtask

  task automatic drain_expect(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      chk("drain_valid", 32'(bus.rd_valid), 32'd1);
      chk("drain_data", bus.rd_data, 32'(i));
      bus.rd_ready = 1'b1;
      cyc();
      bus.rd_ready = 1'b0;
    end
  endtask

  initial begin
    int exp_rd;
    int pw, pr;

    idle();
    reset = 1'b1;
    cyc();
    cyc();
    chk("rst_count",    32'(bus.count),    32'd0);
    chk("rst_empty",    32'(bus.empty),    32'd1);
    chk("rst_full",     32'(bus.full),     32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    reset = 1'b0;

    // single write, latency 1
    bus.wr_en   = 1'b1;
    bus.wr_data = 26'h2AAAAAA;
    cyc();
    idle();
    chk("one_valid", 32'(bus.rd_valid), 32'd1);
    chk("one_data",  bus.rd_data,       32'h02AAAAAA);
    chk("one_count", 32'(bus.count),    32'd1);
    chk("one_empty", 32'(bus.empty),    32'd0);

    // fill, drop 17th, drain in order
    do_reset();
    fill(16);
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_count", 32'(bus.count), 32'd16);
    bus.wr_en   = 1'b1;
    bus.wr_data = 26'h3FFFFFF;
    cyc();
    idle();
    chk("drop_ovf",   32'(bus.overflow), 32'd1);
    chk("drop_count", 32'(bus.count),    32'd16);
    drain_expect(0, 16);
    chk("drained_empty", 32'(bus.empty), 32'd1);

    // overflow_clr alone, then coincident with a drop
    bus.overflow_clr = 1'b1;
    cyc();
    idle();
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    fill(16);
    bus.wr_en        = 1'b1;
    bus.wr_data      = 26'h5;
    bus.overflow_clr = 1'b1;
    cyc();
    idle();
    chk("ovf_set_wins", 32'(bus.overflow), 32'd1);

    // simultaneous write and read while full
    do_reset();
    fill(16);
    chk("fr_head", bus.rd_data, 32'h0);
    bus.wr_en    = 1'b1;
    bus.wr_data  = 26'h0001234;
    bus.rd_ready = 1'b1;
    cyc();
    idle();
    chk("fr_count", 32'(bus.count),    32'd16);
    chk("fr_ovf",   32'(bus.overflow), 32'd0);
    drain_expect(1, 15);
    chk("fr_last", bus.rd_data, 32'h00001234);
    bus.rd_ready = 1'b1;
    cyc();
    idle();
    chk("fr_empty", 32'(bus.empty), 32'd1);

    // streaming through two pointer wraps
    do_reset();
    exp_rd = 0;
    for (int k = 0; k <= 40; k++) begin
      bus.rd_ready = 1'b1;
      bus.wr_en    = (k < 40);
      bus.wr_data  = 26'(k + 100);
      if (bus.rd_valid) begin
        chk("stream_data", bus.rd_data, 32'(exp_rd + 100));
        exp_rd++;
      end
      cyc();
      chk("stream_cnt_le1", 32'(bus.count <= 5'd1), 32'd1);
    end
    idle();
    chk("stream_reads", 32'(exp_rd), 32'd40);
    chk("stream_ovf",   32'(bus.overflow), 32'd0);

    // clear overrides a concurrent write
    do_reset();
    fill(5);
    bus.clear   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 26'h77;
    cyc();
    idle();
    chk("clr_count", 32'(bus.count),    32'd0);
    chk("clr_empty", 32'(bus.empty),    32'd1);
    chk("clr_ovf",   32'(bus.overflow), 32'd0);
    cyc();
    chk("clr_still_empty", 32'(bus.rd_valid), 32'd0);

    // randomized traffic with occasional clear, overflow_clr and reset
    do_reset();
    pw = 50;
    pr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        pw = $urandom_range(90, 10);
        pr = $urandom_range(90, 10);
      end
      bus.wr_en        = ($urandom_range(99) < pw);
      bus.wr_data      = 26'($urandom);
      bus.rd_ready     = ($urandom_range(99) < pr);
      bus.clear        = ($urandom_range(199) == 0);
      bus.overflow_clr = ($urandom_range(15) == 0);
      reset            = ($urandom_range(499) == 0);
      cyc();
    end
    reset = 1'b0;
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
